// File: rtl/draw_pkg.sv
// Shared definitions for the frame draw scheduler and the draw engines it sequences.
package draw_pkg;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAW,
      S_TICK,
      S_WAIT
   } sched_state_t;

   // Bits needed to hold 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/frame_draw_scheduler_if.sv
// Engine handshake plus the shared plot port towards vga_adapter.
interface frame_draw_scheduler_if
   import draw_pkg::*;
#(
   parameter int NUM_ENGINES = 3
) ();
   logic [NUM_ENGINES-1:0]          eng_enable;
   logic [NUM_ENGINES-1:0]          eng_done;
   logic [X_W*NUM_ENGINES-1:0]      eng_x;
   logic [Y_W*NUM_ENGINES-1:0]      eng_y;
   logic [COLOUR_W*NUM_ENGINES-1:0] eng_colour;
   logic [NUM_ENGINES-1:0]          eng_plot;
   logic [X_W-1:0]                  x;
   logic [Y_W-1:0]                  y;
   logic [COLOUR_W-1:0]             colour;
   logic                            plot;

   modport master (
      output eng_enable, x, y, colour, plot,
      input  eng_done, eng_x, eng_y, eng_colour, eng_plot
   );

   modport slave (
      input  eng_enable, x, y, colour, plot,
      output eng_done, eng_x, eng_y, eng_colour, eng_plot
   );
endinterface

// File: rtl/frame_draw_scheduler_sat_counter.sv
// Up-counter that stops at MAX; used for the frame timer and the engine watchdog.
module sat_counter
   import draw_pkg::*;
#(
   parameter  int MAX = 1,
   localparam int W   = cnt_width(MAX)
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] q,
   output logic         at_max
);
   assign at_max = (q == W'(MAX));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (en && !at_max) begin
         q <= q + W'(1);
      end
   end
endmodule

// File: rtl/frame_draw_scheduler.sv
// Per-frame sequencer of the draw engines sharing the vga_adapter plot port.
//
//   state  | meaning
//   IDLE   | not running; waits for run
//   DRAW   | engine idx enabled (or skipped for one cycle if masked)
//   TICK   | one-cycle game-state tick, frame_count++
//   WAIT   | holds until the frame timer reaches FRAME_CYCLES-1
module frame_draw_scheduler
   import draw_pkg::*;
#(
   parameter int NUM_ENGINES     = 3,
   parameter int FRAME_CYCLES    = 833333,
   parameter int WATCHDOG_CYCLES = 65536
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   run,
   input  logic [NUM_ENGINES-1:0] eng_mask,
   input  logic                   err_clear,
   frame_draw_scheduler_if.master bus,
   output logic                   tick,
   output logic                   busy,
   output logic [15:0]            frame_count,
   output logic [NUM_ENGINES-1:0] wd_err,
   output logic                   overrun
);
   localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENGINES - 1);

   sched_state_t           state, state_nxt;
   logic [IDX_W-1:0]       idx, idx_nxt;
   logic [NUM_ENGINES-1:0] enable_nxt, wd_set;
   logic                   active, advance, ovr_set, fc_inc;
   logic                   ft_clear, ft_max, wd_clear, wd_max;
   logic [cnt_width(FRAME_CYCLES-1)-1:0]    ft_q;
   logic [cnt_width(WATCHDOG_CYCLES-1)-1:0] wd_q;
   logic                   unused_q;

   // Only the terminal-count flags drive decisions.
   assign unused_q = ^{ft_q, wd_q};

   sat_counter #(.MAX(FRAME_CYCLES - 1)) u_frame_timer (
      .clock(clock), .resetn(resetn), .clear(ft_clear),
      .en(state != S_IDLE), .q(ft_q), .at_max(ft_max)
   );

   sat_counter #(.MAX(WATCHDOG_CYCLES - 1)) u_watchdog (
      .clock(clock), .resetn(resetn), .clear(wd_clear),
      .en(state == S_DRAW), .q(wd_q), .at_max(wd_max)
   );

   assign active   = bus.eng_enable[idx];
   assign wd_clear = (state != S_DRAW) || advance;
   assign tick     = (state == S_TICK);
   assign busy     = (state != S_IDLE);

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      advance    = 1'b0;
      ft_clear   = 1'b0;
      fc_inc     = 1'b0;
      wd_set     = '0;
      enable_nxt = '0;
      case (state)
         S_IDLE: begin
            if (run) begin
               state_nxt = S_DRAW;
               idx_nxt   = '0;
               ft_clear  = 1'b1;
            end
         end
         S_DRAW: begin
            // A masked slot has no enable and moves on after one cycle.
            advance = !active || bus.eng_done[idx] || wd_max;
            if (active && !bus.eng_done[idx] && wd_max) begin
               wd_set[idx] = 1'b1;
            end
            if (advance) begin
               if (idx == LAST_IDX) begin
                  state_nxt = S_TICK;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         S_TICK: begin
            state_nxt = S_WAIT;
            fc_inc    = 1'b1;
         end
         S_WAIT: begin
            if (ft_max) begin
               state_nxt = run ? S_DRAW : S_IDLE;
               idx_nxt   = '0;
               ft_clear  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (state_nxt == S_DRAW && eng_mask[idx_nxt]) begin
         enable_nxt[idx_nxt] = 1'b1;
      end
   end

   assign ovr_set = ft_max && (state == S_DRAW || state == S_TICK);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= S_IDLE;
         idx            <= '0;
         bus.eng_enable <= '0;
         frame_count    <= '0;
         wd_err         <= '0;
         overrun        <= 1'b0;
      end else begin
         state          <= state_nxt;
         idx            <= idx_nxt;
         bus.eng_enable <= enable_nxt;
         if (fc_inc) begin
            frame_count <= frame_count + 16'd1;
         end
         // A new error in the same cycle as err_clear keeps the flag set.
         wd_err  <= (wd_err & ~{NUM_ENGINES{err_clear}}) | wd_set;
         overrun <= (overrun & ~err_clear) | ovr_set;
      end
   end

   always_comb begin
      bus.x      = '0;
      bus.y      = '0;
      bus.colour = '0;
      bus.plot   = 1'b0;
      if (active) begin
         bus.x      = bus.eng_x[idx*X_W +: X_W];
         bus.y      = bus.eng_y[idx*Y_W +: Y_W];
         bus.colour = bus.eng_colour[idx*COLOUR_W +: COLOUR_W];
         bus.plot   = bus.eng_plot[idx];
      end
   end
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Randomised bench for frame_draw_scheduler; expected frame schedules are derived per frame from engine lengths and mask.
module tb_frame_draw_scheduler;
   import draw_pkg::*;

   localparam int N  = 3;
   localparam int FC = 100;
   localparam int WD = 40;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          run = 1'b0;
   logic          err_clear = 1'b0;
   logic [N-1:0]  eng_mask = '1;
   logic          tick, busy, overrun;
   logic [15:0]   frame_count;
   logic [N-1:0]  wd_err;

   int            checks = 0;
   int            failures = 0;
   int            cur_len[N];
   int            cnt[N];
   int            cyc = 0;
   int            last_start = -1;
   int            last_period = 0;
   bit            pix_fixed = 1'b0;
   logic [15:0]   exp_fc = '0;
   logic [N-1:0]  exp_wd = '0;
   logic          exp_ovr = 1'b0;

   frame_draw_scheduler_if #(.NUM_ENGINES(N)) bus ();

   frame_draw_scheduler #(
      .NUM_ENGINES(N), .FRAME_CYCLES(FC), .WATCHDOG_CYCLES(WD)
   ) dut (
      .clock(clock), .resetn(resetn), .run(run), .eng_mask(eng_mask),
      .err_clear(err_clear), .bus(bus), .tick(tick), .busy(busy),
      .frame_count(frame_count), .wd_err(wd_err), .overrun(overrun)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int rand_len();
      return ($urandom_range(9) == 0) ? 0 : int'($urandom_range(45, 1));
   endfunction

   // Engine stubs: done in the len-th enabled cycle (len 0 = never); random done while not enabled.
   task automatic drive_engines();
      for (int k = 0; k < N; k++) begin
         if (bus.eng_enable[k]) cnt[k]++;
         else cnt[k] = 0;
         bus.eng_done[k] = bus.eng_enable[k] ? (cur_len[k] != 0 && cnt[k] == cur_len[k])
                                             : 1'($urandom_range(1));
         bus.eng_x[8*k +: 8]      = 8'($urandom);
         bus.eng_y[7*k +: 7]      = 7'($urandom);
         bus.eng_colour[3*k +: 3] = 3'($urandom);
      end
      bus.eng_plot = N'($urandom);
      if (pix_fixed) begin
         bus.eng_x[15:8]     = 8'd159;
         bus.eng_y[13:7]     = 7'd119;
         bus.eng_colour[5:3] = 3'd7;
         bus.eng_plot        = '1;
      end
   endtask

   task automatic step();
      @(posedge clock);
      cyc++;
      #1;
      drive_engines();
      #1;
   endtask

   task automatic check_pixel(input logic [N-1:0] en);
      logic [7:0] ex;
      logic [6:0] ey;
      logic [2:0] ec;
      logic       ep;
      ex = '0; ey = '0; ec = '0; ep = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (en[k]) begin
            ex = bus.eng_x[8*k +: 8];
            ey = bus.eng_y[7*k +: 7];
            ec = bus.eng_colour[3*k +: 3];
            ep = bus.eng_plot[k];
         end
      end
      check("x", 32'(bus.x), 32'(ex));
      check("y", 32'(bus.y), 32'(ey));
      check("colour", 32'(bus.colour), 32'(ec));
      check("plot", 32'(bus.plot), 32'(ep));
   endtask

   task automatic check_idle();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_enable", 32'(bus.eng_enable), 32'd0);
      check("idle_tick", 32'(tick), 32'd0);
      check_pixel('0);
   endtask

   task automatic run_frame(input int l0, input int l1, input int l2, input logic [N-1:0] mask,
                            input bit stop, input int abort_at);
      logic [N-1:0] sched[$];
      logic [N-1:0] frame_wd;
      logic [N-1:0] en_e;
      int           d, total, n;
      bit           frame_ovr;
      cur_len[0] = l0; cur_len[1] = l1; cur_len[2] = l2;
      eng_mask = mask;
      frame_wd = '0;
      for (int k = 0; k < N; k++) begin
         if (mask[k]) begin
            if (cur_len[k] == 0 || cur_len[k] > WD) begin
               n = WD;
               frame_wd[k] = 1'b1;
            end else begin
               n = cur_len[k];
            end
            repeat (n) sched.push_back(N'(1 << k));
         end else begin
            sched.push_back('0);
         end
      end
      d = sched.size();
      frame_ovr = (d + 2 > FC);
      total = frame_ovr ? d + 2 : FC;
      for (int c = 0; c < total; c++) begin
         step();
         if (c == abort_at) return;
         if (stop && c == 2) run = 1'b0;
         en_e = (c < d) ? sched[c] : '0;
         check("eng_enable", 32'(bus.eng_enable), 32'(en_e));
         check("tick", 32'(tick), 32'(c == d));
         check("busy", 32'(busy), 32'd1);
         check_pixel(en_e);
         if (c == 0 && last_start >= 0) check("frame_period", 32'(cyc - last_start), 32'(last_period));
         if (c == 0) last_start = cyc;
         if (c == d + 1) begin
            exp_fc  = exp_fc + 16'd1;
            exp_wd  = exp_wd | frame_wd;
            exp_ovr = exp_ovr | frame_ovr;
            check("frame_count", 32'(frame_count), 32'(exp_fc));
            check("wd_err", 32'(wd_err), 32'(exp_wd));
            check("overrun", 32'(overrun), 32'(exp_ovr));
         end
      end
      last_period = total;
      if (stop) last_start = -1;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.eng_done = '0; bus.eng_x = '0; bus.eng_y = '0; bus.eng_colour = '0; bus.eng_plot = '0;
      cur_len = '{1, 1, 1};
      cnt = '{0, 0, 0};
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_enable", 32'(bus.eng_enable), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_wd_err", 32'(wd_err), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check_pixel('0);
      @(negedge clock);
      resetn = 1'b1;
      repeat (3) begin step(); check_idle(); end

      run = 1'b1;
      run_frame(10, 20, 5, '1, 1'b0, -1);
      pix_fixed = 1'b1;
      run_frame(10, 20, 5, '1, 1'b0, -1);
      pix_fixed = 1'b0;
      run_frame(10, 20, 0, '1, 1'b0, -1);
      run_frame(50, 40, 30, '1, 1'b0, -1);
      run_frame(10, 20, 5, '1, 1'b0, -1);
      for (int f = 0; f < 6; f++) begin
         run_frame(rand_len(), rand_len(), rand_len(), N'($urandom), 1'b0, -1);
      end

      run_frame(10, 20, 5, 3'b101, 1'b1, -1);
      repeat (4) begin step(); check_idle(); end

      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      exp_wd = '0;
      exp_ovr = 1'b0;
      check("clear_wd_err", 32'(wd_err), 32'd0);
      check("clear_overrun", 32'(overrun), 32'd0);
      check("clear_frame_count", 32'(frame_count), 32'(exp_fc));

      run = 1'b1;
      run_frame(10, 20, 5, '1, 1'b0, 15);
      resetn = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_enable", 32'(bus.eng_enable), 32'd0);
      check("mid_rst_tick", 32'(tick), 32'd0);
      check("mid_rst_frame_count", 32'(frame_count), 32'd0);
      check("mid_rst_wd_err", 32'(wd_err), 32'd0);
      check("mid_rst_overrun", 32'(overrun), 32'd0);
      check_pixel('0);
      exp_fc = '0;
      exp_wd = '0;
      exp_ovr = 1'b0;
      last_start = -1;
      cnt = '{0, 0, 0};
      @(negedge clock);
      resetn = 1'b1;
      run_frame(10, 20, 5, '1, 1'b1, -1);
      step();
      check_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
